cla_addsub_pipe: RTL and testbench
==================================

// Module: cla_addsub_pipe
// PURPOSE
//  Parametrised, pipelined carry-lookahead adder/subtractor for the ALU datapath.
//  Supports ADD, SUB, ADC and SBB, with optional signed saturation, and produces carry, overflow, zero and negative flags.
//  Connects to the ALU issue logic on one side and to writeback on the other, through valid/ready handshakes.
// PARAMETERS
//  WIDTH   16  operand/result width; must be a multiple of GROUP
//  GROUP   4   bits per lookahead group (cla_group instance)
//  STAGES  2   pipeline depth, legal values 1 or 2; this is also the latency in cycles
// PORTS
//  clk         in   1      single clock, rising edge
//  rst_n       in   1      asynchronous active-low reset
//  in_valid    in   1      input operation is valid
//  in_ready    out  1      block can accept an operation this cycle
//  in_a        in   WIDTH  operand A
//  in_b        in   WIDTH  operand B
//  in_op       in   2      00 ADD, 01 SUB, 10 ADC, 11 SBB
//  in_cin      in   1      carry-in for ADC/SBB (SBB: 1 = no borrow); ignored for ADD/SUB
//  in_sat      in   1      1 = clamp the result on signed overflow
//  out_valid   out  1      result is valid
//  out_ready   in   1      downstream accepts the result
//  out_result  out  WIDTH  sum/difference (saturated if in_sat=1)
//  out_cout    out  1      raw carry out of the MSB (before saturation)
//  out_ovfl    out  1      signed overflow of the unsaturated result
//  out_zero    out  1      out_result == 0
//  out_neg     out  1      out_result[WIDTH-1]
// BEHAVIOUR
//  Operand B preparation:
//   - SUB and SBB invert B (b' = ~in_b).
//   - Effective carry-in: ADD=0, SUB=1, ADC/SBB=in_cin.
//   - Single add of a + b' + cin; no second adder pass.
//  Arithmetic:
//   - ovfl = (a[MSB] == b'[MSB]) && (sum[MSB] != a[MSB]).
//   - With in_sat=1 and ovfl=1: result = 0x7F..F if a[MSB]=0, else 0x80..0.
//   - cout and ovfl always describe the unsaturated sum.
//   - zero and neg are computed on the final (possibly saturated) result.
//  Pipeline:
//   - STAGES=1: operands, add and flags are computed combinationally into one output register.
//   - STAGES=2: stage 1 registers group P/G, group sums and control bits; stage 2 resolves group carries with the lookahead unit and registers result and flags.
//  Handshake:
//   - Each stage k holds valid_k; ready_k = !valid_k || ready_(k+1); ready_last = out_ready.
//   - in_ready = ready_0; a transfer occurs when in_valid && in_ready.
//   - With out_ready held at 1, throughput is 1 op/cycle and latency is exactly STAGES cycles.
//   - Backpressure (out_ready=0): up to STAGES ops are held, in order. No op is dropped or duplicated.
//   - While out_valid=1 && out_ready=0, out_* stay stable.
//   - Accepting an input and emitting an output in the same cycle is legal when the pipe is full and out_ready=1.
//  Reset (asynchronous, rst_n=0):
//   - All valid bits and out_* clear to 0 immediately.
//   - in_ready is forced to 0 while rst_n=0 and rises one cycle after deassertion.
//   - Ops in flight when reset asserts are discarded and never appear at the output.
//  Wrap-around: results are modulo 2^WIDTH; cout is the only record of the carry.
// STRUCTURE
//  Package alu_pkg:
//   - op encoding constants OP_ADD/OP_SUB/OP_ADC/OP_SBB (2-bit localparams)
//   - typedef/struct for the flag bundle {cout, ovfl, zero, neg}
//  Sub-module cla_group (GROUP bits in; outputs group sum, P, G):
//   - WIDTH/GROUP instances, generated
//   - group carries come from a lookahead block inside cla_addsub_pipe
//  Handshake/valid logic is local; no FIFO sub-module.
// TESTING (WIDTH=16, STAGES=2, out_ready=1 unless stated)
//  ADD 0x7FFF+0x0001, sat=0 -> result 0x8000, ovfl=1, neg=1, cout=0, exactly 2 cycles after accept
//  Same with sat=1 -> 0x7FFF, ovfl=1, neg=0; SUB 0x8000-0x0001 sat=1 -> 0x8000, ovfl=1
//  SUB 0x0005-0x0005 -> 0x0000, zero=1, cout=1
//  SUB 0x0000-0x0001 -> 0xFFFF, cout=0, neg=1
//  ADC 0xFFFF+0x0000 cin=1 -> 0x0000, cout=1, zero=1
//  SBB 0x0010-0x0001 cin=0 -> 0x000E
//  Backpressure, 4 back-to-back ops with out_ready=0:
//   - in_ready falls after 2 accepts; out_* stable
//   - on out_ready=1, all 4 ops emerge in order at 1 per cycle
//  Reset with 2 ops in flight: out_valid=0 at once; nothing emerges after release; in_ready=1 one cycle later
//  Random sweep against a reference model with STAGES=1 and 2, WIDTH=8/16/32, random in_valid/out_ready

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU add/subtract datapath: opcode encodings
// and the result flag bundle.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ADC = 2'b10;
  localparam logic [1:0] OP_SBB = 2'b11;

  typedef struct packed {
    logic cout;
    logic ovfl;
    logic zero;
    logic neg;
  } flags_t;

endpackage

// File: rtl/cla_group.sv
// One lookahead group: produces the group sum for both possible carry-ins
// plus group propagate/generate, so the final carry only selects a sum.
module cla_group #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  output logic [GROUP-1:0] sum0,
  output logic [GROUP-1:0] sum1,
  output logic             p,
  output logic             g
);

  logic [GROUP-1:0] pb;
  logic [GROUP-1:0] gb;
  logic [GROUP:0]   c0;
  logic [GROUP:0]   c1;

  // Bit-level propagate/generate and in-group carries for cin=0 and cin=1.
  always_comb begin
    pb    = a ^ b;
    gb    = a & b;
    c0    = '0;
    c1    = '0;
    c1[0] = 1'b1;
    for (int i = 0; i < GROUP; i++) begin
      c0[i+1] = gb[i] | (pb[i] & c0[i]);
      c1[i+1] = gb[i] | (pb[i] & c1[i]);
    end
    sum0 = pb ^ c0[GROUP-1:0];
    sum1 = pb ^ c1[GROUP-1:0];
    p    = &pb;
    g    = c0[GROUP];
  end

endmodule

// File: rtl/cla_addsub_pipe.sv
// Pipelined carry-lookahead adder/subtractor (ADD/SUB/ADC/SBB) with optional
// signed saturation and carry/overflow/zero/negative flags. STAGES=2 splits
// the datapath after the per-group sums; STAGES=1 registers only the result.
module cla_addsub_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int GROUP  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  input  logic             in_cin,
  input  logic             in_sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_cout,
  output logic             out_ovfl,
  output logic             out_zero,
  output logic             out_neg
);

  localparam int NG  = WIDTH / GROUP;
  localparam int MSB = WIDTH - 1;
  // Group sums (both carry variants), group P/G, cin, operand MSBs, sat.
  localparam int SW  = 2 * WIDTH + 2 * NG + 4;

  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  // Operand B conditioning and effective carry-in by opcode.
  always_comb begin
    b_eff   = in_b;
    cin_eff = 1'b0;
    case (in_op)
      OP_ADD: begin b_eff = in_b;  cin_eff = 1'b0;   end
      OP_SUB: begin b_eff = ~in_b; cin_eff = 1'b1;   end
      OP_ADC: begin b_eff = in_b;  cin_eff = in_cin; end
      OP_SBB: begin b_eff = ~in_b; cin_eff = in_cin; end
      default: begin b_eff = in_b; cin_eff = 1'b0;   end
    endcase
  end

  logic [WIDTH-1:0] grp_sum0;
  logic [WIDTH-1:0] grp_sum1;
  logic [NG-1:0]    grp_p;
  logic [NG-1:0]    grp_g;

  for (genvar k = 0; k < NG; k++) begin : g_grp
    cla_group #(.GROUP(GROUP)) u_grp (
      .a    (in_a[k*GROUP +: GROUP]),
      .b    (b_eff[k*GROUP +: GROUP]),
      .sum0 (grp_sum0[k*GROUP +: GROUP]),
      .sum1 (grp_sum1[k*GROUP +: GROUP]),
      .p    (grp_p[k]),
      .g    (grp_g[k])
    );
  end

  logic [SW-1:0] stage_in;
  logic [SW-1:0] stage_rs;
  assign stage_in = {grp_sum0, grp_sum1, grp_p, grp_g, cin_eff, in_a[MSB], b_eff[MSB], in_sat};

  // in_ready stays low in reset and for the first cycle after release.
  logic init_q;
  logic init_d;
  assign init_d = 1'b1;

  // Reset-release tracker for in_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) init_q <= 1'b0;
    else        init_q <= init_d;
  end

  logic   out_valid_q, out_valid_d;
  logic   out_stage_rdy;
  logic   rs_valid;
  assign out_stage_rdy = !out_valid_q || out_ready;

  if (STAGES == 2) begin : g_two
    logic          s1_valid_q, s1_valid_d;
    logic [SW-1:0] s1_data_q, s1_data_d;
    logic          s1_rdy;

    assign s1_rdy   = !s1_valid_q || out_stage_rdy;
    assign in_ready = init_q && s1_rdy;
    assign stage_rs = s1_data_q;
    assign rs_valid = s1_valid_q;

    // Stage 1 load/hold: capture group results when the stage can advance.
    always_comb begin
      s1_valid_d = s1_valid_q;
      s1_data_d  = s1_data_q;
      if (in_ready) begin
        s1_valid_d = in_valid;
        if (in_valid) s1_data_d = stage_in;
      end
    end

    // Stage 1 registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_valid_q <= 1'b0;
        s1_data_q  <= '0;
      end else begin
        s1_valid_q <= s1_valid_d;
        s1_data_q  <= s1_data_d;
      end
    end
  end else begin : g_one
    assign in_ready = init_q && out_stage_rdy;
    assign stage_rs = stage_in;
    assign rs_valid = in_valid && in_ready;
  end

  logic [WIDTH-1:0] rs_sum0, rs_sum1;
  logic [NG-1:0]    rs_p, rs_g;
  logic             rs_cin, rs_a_msb, rs_b_msb, rs_sat;
  assign {rs_sum0, rs_sum1, rs_p, rs_g, rs_cin, rs_a_msb, rs_b_msb, rs_sat} = stage_rs;

  logic [NG:0]      carry;
  logic [WIDTH-1:0] raw_sum;
  logic [WIDTH-1:0] res;
  logic             ovfl;
  flags_t           fl;

  // Group carry lookahead, sum selection, overflow, saturation and flags.
  always_comb begin
    carry    = '0;
    carry[0] = rs_cin;
    for (int k = 0; k < NG; k++) begin
      carry[k+1] = rs_g[k] | (rs_p[k] & carry[k]);
    end
    raw_sum = '0;
    for (int k = 0; k < NG; k++) begin
      raw_sum[k*GROUP +: GROUP] = carry[k] ? rs_sum1[k*GROUP +: GROUP]
                                           : rs_sum0[k*GROUP +: GROUP];
    end
    ovfl = (rs_a_msb == rs_b_msb) && (raw_sum[MSB] != rs_a_msb);
    res  = raw_sum;
    if (rs_sat && ovfl) begin
      res = rs_a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
    fl.cout = carry[NG];
    fl.ovfl = ovfl;
    fl.zero = (res == '0);
    fl.neg  = res[MSB];
  end

  logic [WIDTH-1:0] out_result_q, out_result_d;
  flags_t           out_flags_q, out_flags_d;

  // Output stage load/hold; data is frozen while the consumer stalls.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_flags_d  = out_flags_q;
    if (out_stage_rdy) begin
      out_valid_d = rs_valid;
      if (rs_valid) begin
        out_result_d = res;
        out_flags_d  = fl;
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_flags_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_flags_q  <= out_flags_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_cout   = out_flags_q.cout;
  assign out_ovfl   = out_flags_q.ovfl;
  assign out_zero   = out_flags_q.zero;
  assign out_neg    = out_flags_q.neg;

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Bench for cla_addsub_pipe: directed vectors on a 16-bit two-stage instance,
// plus a random sweep over 16/2, 8/1 and 32/2 instances against a model.
module tb_cla_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  iv = 3'b000;
  logic [2:0]  ordy = 3'b111;
  logic [31:0] a_bus = '0;
  logic [31:0] b_bus = '0;
  logic [1:0]  op = 2'b00;
  logic        cin = 1'b0;
  logic        sat = 1'b0;

  logic        rdy0, rdy1, rdy2, vld0, vld1, vld2;
  logic [15:0] r0;
  logic [7:0]  r1;
  logic [31:0] r2;
  logic        co0, of0, z0, n0, co1, of1, z1, n1, co2, of2, z2, n2;
  logic [2:0]  irdy, ov;
  logic [31:0] res_v [3];
  logic [3:0]  fl_v  [3];

  int checks = 0;
  int passed = 0;
  int wdt [3] = '{16, 8, 32};

  always #5 clk = ~clk;

  cla_addsub_pipe #(.WIDTH(16), .GROUP(4), .STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(rdy0),
    .in_a(a_bus[15:0]), .in_b(b_bus[15:0]), .in_op(op), .in_cin(cin), .in_sat(sat),
    .out_valid(vld0), .out_ready(ordy[0]), .out_result(r0),
    .out_cout(co0), .out_ovfl(of0), .out_zero(z0), .out_neg(n0));

  cla_addsub_pipe #(.WIDTH(8), .GROUP(4), .STAGES(1)) dut_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(rdy1),
    .in_a(a_bus[7:0]), .in_b(b_bus[7:0]), .in_op(op), .in_cin(cin), .in_sat(sat),
    .out_valid(vld1), .out_ready(ordy[1]), .out_result(r1),
    .out_cout(co1), .out_ovfl(of1), .out_zero(z1), .out_neg(n1));

  cla_addsub_pipe #(.WIDTH(32), .GROUP(8), .STAGES(2)) dut_w32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(rdy2),
    .in_a(a_bus), .in_b(b_bus), .in_op(op), .in_cin(cin), .in_sat(sat),
    .out_valid(vld2), .out_ready(ordy[2]), .out_result(r2),
    .out_cout(co2), .out_ovfl(of2), .out_zero(z2), .out_neg(n2));

  assign irdy     = {rdy2, rdy1, rdy0};
  assign ov       = {vld2, vld1, vld0};
  assign res_v[0] = {16'h0000, r0};
  assign res_v[1] = {24'h000000, r1};
  assign res_v[2] = r2;
  assign fl_v[0]  = {co0, of0, z0, n0};
  assign fl_v[1]  = {co1, of1, z1, n1};
  assign fl_v[2]  = {co2, of2, z2, n2};

  // Reference: integer arithmetic on unsigned and signed interpretations.
  // Returns {cout, ovfl, zero, neg, result[31:0]}.
  function automatic logic [35:0] model(input int w, input logic [31:0] a,
                                        input logic [31:0] b, input logic [1:0] o,
                                        input logic ci_in, input logic s);
    longint m, half, ua, ub, sa, sb, us, ss, ci;
    logic c, v, z, ng;
    logic [31:0] r;
    m    = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua   = longint'(a) & m;
    ub   = longint'(b) & m;
    sa   = (ua >= half) ? ua - (m + 1) : ua;
    sb   = (ub >= half) ? ub - (m + 1) : ub;
    ci   = longint'(ci_in);
    case (o)
      2'b00:   begin us = ua + ub;            ss = sa + sb;            c = (us > m);  end
      2'b10:   begin us = ua + ub + ci;       ss = sa + sb + ci;       c = (us > m);  end
      2'b01:   begin us = ua - ub;            ss = sa - sb;            c = (us >= 0); end
      default: begin us = ua - ub - (1 - ci); ss = sa - sb - (1 - ci); c = (us >= 0); end
    endcase
    v = (ss > half - 1) || (ss < -half);
    r = 32'(us & m);
    if (s && v) r = (ss > 0) ? 32'(half - 1) : 32'(half);
    z  = (r == 32'd0);
    ng = r[w-1];
    return {c, v, z, ng, r};
  endfunction

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (irdy !== 3'b000 || ov !== 3'b000 || r0 !== 16'h0000 || fl_v[0] !== 4'b0000) begin
      $display("FAIL reset_state: in_ready=%b out_valid=%b r=%h f=%b, want 000 000 0000 0000",
               irdy, ov, r0, fl_v[0]);
    end else passed++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (irdy !== 3'b000) $display("FAIL ready_after_release: in_ready=%b want 000", irdy);
    else passed++;
    @(negedge clk);
    checks++;
    if (irdy !== 3'b111) $display("FAIL ready_one_cycle_later: in_ready=%b want 111", irdy);
    else passed++;
  endtask

  task automatic do_op(input string name, input logic [15:0] a, input logic [15:0] b,
                       input logic [1:0] o, input logic c, input logic s,
                       input logic [15:0] exp_r, input logic [3:0] exp_f);
    int n;
    @(posedge clk); #1;
    ordy[0] = 1'b1;
    a_bus = {16'h0000, a};
    b_bus = {16'h0000, b};
    op = o; cin = c; sat = s;
    iv[0] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!irdy[0] && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!irdy[0]) begin
      $display("FAIL %s_accept: in_ready=%b want 1 within 10 cycles", name, irdy[0]);
      iv[0] = 1'b0;
      return;
    end
    passed++;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (ov[0] !== 1'b0) $display("FAIL %s_latency: out_valid=%b one cycle after accept, want 0", name, ov[0]);
    else passed++;
    @(negedge clk);
    checks++;
    if (ov[0] !== 1'b1 || r0 !== exp_r || fl_v[0] !== exp_f) begin
      $display("FAIL %s: valid=%b r=%h f(c,v,z,n)=%b, want valid=1 r=%h f=%b",
               name, ov[0], r0, fl_v[0], exp_r, exp_f);
    end else passed++;
  endtask

  task automatic test_arith();
    do_op("add_ovfl",      16'h7FFF, 16'h0001, 2'b00, 1'b0, 1'b0, 16'h8000, 4'b0101);
    do_op("add_ovfl_sat",  16'h7FFF, 16'h0001, 2'b00, 1'b0, 1'b1, 16'h7FFF, 4'b0100);
    do_op("sub_ovfl_sat",  16'h8000, 16'h0001, 2'b01, 1'b0, 1'b1, 16'h8000, 4'b1101);
    do_op("sub_zero",      16'h0005, 16'h0005, 2'b01, 1'b0, 1'b0, 16'h0000, 4'b1010);
    do_op("sub_borrow",    16'h0000, 16'h0001, 2'b01, 1'b0, 1'b0, 16'hFFFF, 4'b0001);
    do_op("adc_wrap",      16'hFFFF, 16'h0000, 2'b10, 1'b1, 1'b0, 16'h0000, 4'b1010);
    do_op("sbb_borrow",    16'h0010, 16'h0001, 2'b11, 1'b0, 1'b0, 16'h000E, 4'b1000);
    do_op("sbb_noborrow",  16'h0010, 16'h0001, 2'b11, 1'b1, 1'b0, 16'h000F, 4'b1000);
    do_op("add_cin_ign",   16'h1234, 16'h1111, 2'b00, 1'b1, 1'b0, 16'h2345, 4'b0000);
    do_op("sub_cin_ign",   16'h1000, 16'h0001, 2'b01, 1'b0, 1'b0, 16'h0FFF, 4'b1000);
    do_op("add_neg_sat",   16'h8000, 16'h8000, 2'b00, 1'b0, 1'b1, 16'h8000, 4'b1101);
    do_op("sub_pos_sat",   16'h7FFF, 16'hFFFF, 2'b01, 1'b0, 1'b1, 16'h7FFF, 4'b0100);
  endtask

  task automatic test_back_to_back();
    logic [15:0] ba [4];
    logic [15:0] bb [4];
    logic [1:0]  bo [4];
    logic [15:0] bres [4];
    int idx, nout, first, last;
    logic acc;
    ba[0] = 16'h0001; bb[0] = 16'h0002; bo[0] = 2'b00; bres[0] = 16'h0003;
    ba[1] = 16'h0010; bb[1] = 16'h0020; bo[1] = 2'b00; bres[1] = 16'h0030;
    ba[2] = 16'h0100; bb[2] = 16'h0001; bo[2] = 2'b01; bres[2] = 16'h00FF;
    ba[3] = 16'hAAAA; bb[3] = 16'h1111; bo[3] = 2'b00; bres[3] = 16'hBBBB;
    @(posedge clk); #1;
    ordy[0] = 1'b0; cin = 1'b0; sat = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      iv[0] = (idx < 4);
      if (idx < 4) begin a_bus = {16'h0, ba[idx]}; b_bus = {16'h0, bb[idx]}; op = bo[idx]; end
      @(negedge clk);
      acc = iv[0] && irdy[0];
      @(posedge clk); #1;
      if (acc) idx++;
    end
    checks++;
    if (idx != 2) $display("FAIL bp_accepts: accepted %0d ops while stalled, want 2", idx);
    else passed++;
    @(negedge clk);
    checks++;
    if (irdy[0] !== 1'b0 || ov[0] !== 1'b1 || r0 !== 16'h0003) begin
      $display("FAIL bp_full: in_ready=%b valid=%b r=%h, want 0 1 0003", irdy[0], ov[0], r0);
    end else passed++;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (ov[0] !== 1'b1 || r0 !== 16'h0003 || fl_v[0] !== 4'b0000) begin
        $display("FAIL bp_stable: valid=%b r=%h f=%b, want 1 0003 0000", ov[0], r0, fl_v[0]);
      end else passed++;
    end
    @(posedge clk); #1;
    ordy[0] = 1'b1;
    nout = 0; first = -1; last = -1;
    for (int c = 0; c < 12 && nout < 4; c++) begin
      iv[0] = (idx < 4);
      if (idx < 4) begin a_bus = {16'h0, ba[idx]}; b_bus = {16'h0, bb[idx]}; op = bo[idx]; end
      @(negedge clk);
      acc = iv[0] && irdy[0];
      if (ov[0]) begin
        checks++;
        if (r0 !== bres[nout]) $display("FAIL bp_order: output %0d r=%h want %h", nout, r0, bres[nout]);
        else passed++;
        if (first < 0) first = c;
        last = c;
        nout++;
      end
      @(posedge clk); #1;
      if (acc) idx++;
    end
    iv[0] = 1'b0;
    checks++;
    if (nout != 4 || idx != 4 || last - first != 3) begin
      $display("FAIL bp_drain: outputs=%0d accepts=%0d span=%0d, want 4 4 3", nout, idx, last - first);
    end else passed++;
  endtask

  task automatic test_reset_inflight();
    logic seen;
    @(posedge clk); #1;
    ordy[0] = 1'b1; op = 2'b00; cin = 1'b0; sat = 1'b0;
    a_bus = 32'h1; b_bus = 32'h1; iv[0] = 1'b1;
    @(posedge clk); #1;
    a_bus = 32'h2; b_bus = 32'h2;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    checks++;
    if (ov[0] !== 1'b1) $display("FAIL rst_inflight_setup: valid=%b want 1", ov[0]);
    else passed++;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ov[0] !== 1'b0 || irdy[0] !== 1'b0 || r0 !== 16'h0000) begin
      $display("FAIL rst_async: valid=%b in_ready=%b r=%h, want 0 0 0000", ov[0], irdy[0], r0);
    end else passed++;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (irdy[0] !== 1'b0) $display("FAIL rst_ready_low: in_ready=%b want 0", irdy[0]);
    else passed++;
    @(negedge clk);
    checks++;
    if (irdy[0] !== 1'b1) $display("FAIL rst_ready_high: in_ready=%b want 1", irdy[0]);
    else passed++;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      seen = seen | ov[0];
    end
    checks++;
    if (seen !== 1'b0) $display("FAIL rst_discard: out_valid seen=%b after reset, want 0", seen);
    else passed++;
  endtask

  task automatic test_random_sweep();
    logic [35:0] sb [3][16];
    int          hd [3];
    int          tl [3];
    logic [35:0] hval [3];
    logic [2:0]  held;
    logic [35:0] got, exp;
    held = 3'b000;
    for (int i = 0; i < 3; i++) begin hd[i] = 0; tl[i] = 0; hval[i] = '0; end
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(posedge clk); #1;
      if (cyc < 760) begin
        a_bus = $urandom;
        b_bus = $urandom;
        op    = 2'($urandom_range(0, 3));
        cin   = 1'($urandom_range(0, 1));
        sat   = 1'($urandom_range(0, 1));
        for (int i = 0; i < 3; i++) begin
          iv[i]   = ($urandom_range(0, 3) != 0);
          ordy[i] = ($urandom_range(0, 3) != 0);
        end
      end else begin
        iv = 3'b000;
        ordy = 3'b111;
      end
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        got = {fl_v[i], res_v[i]};
        if (held[i]) begin
          checks++;
          if (ov[i] !== 1'b1 || got !== hval[i]) begin
            $display("FAIL sweep_hold dut%0d: valid=%b out=%h, want 1 %h", i, ov[i], got, hval[i]);
          end else passed++;
        end
        if (ov[i] && ordy[i]) begin
          checks++;
          if (hd[i] == tl[i]) begin
            $display("FAIL sweep_extra dut%0d: unexpected output %h", i, got);
          end else begin
            exp = sb[i][hd[i] % 16];
            hd[i]++;
            if (got !== exp) $display("FAIL sweep dut%0d: out=%h want %h", i, got, exp);
            else passed++;
          end
        end
        held[i] = ov[i] && !ordy[i];
        hval[i] = got;
        if (iv[i] && irdy[i]) begin
          sb[i][tl[i] % 16] = model(wdt[i], a_bus, b_bus, op, cin, sat);
          tl[i]++;
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (hd[i] != tl[i]) $display("FAIL sweep_lost dut%0d: emitted %0d of %0d accepted", i, hd[i], tl[i]);
      else passed++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_arith();
    test_back_to_back();
    test_reset_inflight();
    test_random_sweep();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
